button_event_ctrl: RTL and testbench

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Four-button event generator: PRESS / LONG / REPEAT / RELEASE per button,
// one pending bit per (button, type), fixed-priority arbiter into a 4-deep FIFO.
module button_event_ctrl #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_level,
    input  logic       enable,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_data,
    output logic       evt_overflow,
    input  logic       ovf_clear
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } btn_state_t;

    // Pending-bit offsets within a button's group of four; equal to the type code.
    localparam int EV_PRESS   = 0;
    localparam int EV_LONG    = 1;
    localparam int EV_REPEAT  = 2;
    localparam int EV_RELEASE = 3;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_CYC - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYC - 1);

    logic [3:0]  prev;
    logic [3:0]  rise;
    logic [3:0]  fall;

    btn_state_t  state     [4];
    btn_state_t  state_nxt [4];
    logic [31:0] cnt       [4];
    logic [31:0] cnt_nxt   [4];

    logic [15:0] pending;
    logic [15:0] post;
    logic [15:0] kept;
    logic [15:0] clr_mask;
    logic        drop;

    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic [3:0]  sel_data;

    logic [3:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        pop;
    logic        push;
    logic        can_accept;

    assign rise = btn_level & ~prev;
    assign fall = ~btn_level & prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            prev <= btn_level;
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        post = '0;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            if (!enable) begin
                state_nxt[i] = ST_IDLE;
                cnt_nxt[i]   = '0;
            end else begin
                unique case (state[i])
                    ST_IDLE: begin
                        if (rise[i]) begin
                            state_nxt[i]          = ST_DOWN;
                            cnt_nxt[i]            = '0;
                            post[4*i + EV_PRESS]  = 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        if (fall[i]) begin
                            state_nxt[i]           = ST_IDLE;
                            cnt_nxt[i]             = '0;
                            post[4*i + EV_RELEASE] = 1'b1;
                        end else if (cnt[i] == LONG_LAST) begin
                            state_nxt[i]          = ST_HELD;
                            cnt_nxt[i]            = '0;
                            post[4*i + EV_LONG]   = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 32'd1;
                        end
                    end
                    ST_HELD: begin
                        if (fall[i]) begin
                            state_nxt[i]           = ST_IDLE;
                            cnt_nxt[i]             = '0;
                            post[4*i + EV_RELEASE] = 1'b1;
                        end else if (cnt[i] == REPEAT_LAST) begin
                            cnt_nxt[i]            = '0;
                            post[4*i + EV_REPEAT] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 32'd1;
                        end
                    end
                    default: begin
                        state_nxt[i] = ST_IDLE;
                        cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Lowest pending index wins: button order first, then type order.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = 15; k >= 0; k--) begin
            if (pending[k]) begin
                sel_valid = 1'b1;
                sel_idx   = k[3:0];
            end
        end
    end

    assign sel_data   = {sel_idx[1:0], sel_idx[3:2]};
    assign pop        = evt_valid & evt_ready;
    assign can_accept = (count != 3'd4) | pop;
    assign push       = sel_valid & can_accept;
    assign clr_mask   = push ? (16'd1 << sel_idx) : '0;
    assign kept       = pending & ~clr_mask;
    assign drop       = |(kept & post);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pending <= kept | post;
            if (drop) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clear) begin
                evt_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through count,
    // and the empty case forces evt_data to zero.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sel_data;
    end

    assign evt_valid = (count != 3'd0);
    assign evt_data  = evt_valid ? fifo_mem[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed scenarios plus randomized stimulus, all checked every cycle against
// an elapsed-time reference model of the event generator.
module tb_button_event_ctrl;

    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_level;
    logic       enable;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_data;
    logic       evt_overflow;
    logic       ovf_clear;

    button_event_ctrl #(.LONG_CYC(LONG), .REPEAT_CYC(REP)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .enable       (enable),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_overflow (evt_overflow),
        .ovf_clear    (ovf_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a button is "active" from its press edge; events derive
    // from the number of edges elapsed since that press.
    int         cyc = 0;
    bit [3:0]   m_prev;
    bit         m_act [4];
    int         m_t0  [4];
    bit [15:0]  m_pend;
    logic [3:0] m_q [$];
    bit         m_ovf;

    logic [3:0] log_d [$];
    int         log_t [$];
    logic [3:0] exp_q [$];

    function automatic void model_step();
        bit [15:0] posts;
        bit [15:0] clr;
        bit [15:0] rem;
        int        sel;
        bit        pop;
        bit        acc;
        int        d;
        if (reset) begin
            m_prev = '0;
            m_pend = '0;
            m_ovf  = 1'b0;
            m_q.delete();
            for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
            return;
        end
        posts = '0;
        clr   = '0;
        sel   = -1;
        pop   = (m_q.size() != 0) && evt_ready;
        acc   = (m_q.size() < 4) || pop;
        for (int k = 0; k < 16; k++) if (m_pend[k] && sel < 0) sel = k;
        if (pop) void'(m_q.pop_front());
        if (sel >= 0 && acc) begin
            m_q.push_back({sel[1:0], sel[3:2]});
            clr[sel] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (!enable) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (btn_level[i] && !m_prev[i]) begin
                    m_act[i]   = 1'b1;
                    m_t0[i]    = cyc;
                    posts[4*i] = 1'b1;
                end
            end else if (!btn_level[i] && m_prev[i]) begin
                m_act[i]       = 1'b0;
                posts[4*i + 3] = 1'b1;
            end else begin
                d = cyc - m_t0[i];
                if (d == int'(LONG)) posts[4*i + 1] = 1'b1;
                else if (d > int'(LONG) && ((d - int'(LONG)) % int'(REP)) == 0) posts[4*i + 2] = 1'b1;
            end
        end
        rem    = m_pend & ~clr;
        m_ovf  = (m_ovf && !ovf_clear) || ((rem & posts) != 0);
        m_pend = rem | posts;
        m_prev = btn_level;
    endfunction

    task automatic cycle();
        if (evt_valid && evt_ready) begin
            log_d.push_back(evt_data);
            log_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("valid", 32'(evt_valid), 32'(m_q.size() != 0));
        check("data", 32'(evt_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("overflow", 32'(evt_overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_log();
        log_d.delete();
        log_t.delete();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(log_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_d.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(log_d[i]), 32'(exp_q[i]));
    endtask

    initial begin
        reset     = 1'b1;
        btn_level = 4'b0000;
        enable    = 1'b1;
        evt_ready = 1'b1;
        ovf_clear = 1'b0;
        run(2);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_data", 32'(evt_data), 32'h0);
        check("rst_ovf", 32'(evt_overflow), 32'h0);
        reset = 1'b0;
        run(2);

        // Short tap on button 0: PRESS then RELEASE, no LONG.
        clear_log();
        btn_level = 4'b0001;
        run(3);
        btn_level = 4'b0000;
        run(6);
        exp_q = {4'h0, 4'hC};
        check_seq("tap");

        // Button 2 held for 20 cycles.
        clear_log();
        btn_level = 4'b0100;
        run(20);
        btn_level = 4'b0000;
        run(6);
        exp_q = {4'h2, 4'h6, 4'hA, 4'hA, 4'hE};
        check_seq("hold");
        if (log_t.size() >= 4) begin
            check("hold_long_gap", 32'(log_t[1] - log_t[0]), 32'd8);
            check("hold_rep_gap1", 32'(log_t[2] - log_t[1]), 32'd4);
            check("hold_rep_gap2", 32'(log_t[3] - log_t[2]), 32'd4);
        end

        // All four pressed at once: arbiter order, one per cycle.
        clear_log();
        btn_level = 4'b1111;
        run(6);
        exp_q = {4'h0, 4'h1, 4'h2, 4'h3};
        check_seq("all");
        for (int i = 0; i + 1 < log_t.size(); i++)
            check($sformatf("all_gap_%0d", i), 32'(log_t[i+1] - log_t[i]), 32'd1);
        btn_level = 4'b0000;
        run(8);

        // Stalled consumer: fill FIFO, then force drops.
        evt_ready = 1'b0;
        btn_level = 4'b1111;
        run(6);
        check("stall_valid", 32'(evt_valid), 32'h1);
        check("stall_head", 32'(evt_data), 32'h0);
        btn_level = 4'b0000;
        run(2);
        btn_level = 4'b1111;
        run(2);
        check("stall_no_ovf_yet", 32'(evt_overflow), 32'h0);
        btn_level = 4'b0000;
        run(1);
        check("stall_ovf_release", 32'(evt_overflow), 32'h1);
        btn_level = 4'b1111;
        ovf_clear = 1'b1;
        run(1);
        check("ovf_clear_vs_drop", 32'(evt_overflow), 32'h1);
        run(1);
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(evt_overflow), 32'h0);
        check("stall_head_stable", 32'(evt_data), 32'h0);
        evt_ready = 1'b1;
        btn_level = 4'b0000;
        run(24);
        ovf_clear = 1'b1;
        run(1);
        ovf_clear = 1'b0;

        // Reset with three queued events; button 0 held through reset release.
        evt_ready = 1'b0;
        btn_level = 4'b0111;
        run(5);
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_data", 32'(evt_data), 32'h0);
        check("mid_rst_ovf", 32'(evt_overflow), 32'h0);
        run(5);
        clear_log();
        evt_ready = 1'b1;
        run(3);
        check("post_rst_press", 32'(log_d.size() > 0 ? log_d[0] : 4'hF), 32'h0);
        btn_level = 4'b0000;
        run(8);

        // Enable dropped while button 1 is in HELD, restored while still held.
        btn_level = 4'b0010;
        run(12);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        clear_log();
        run(10);
        check("reenable_quiet", 32'(log_d.size()), 32'd0);
        btn_level = 4'b0000;
        run(2);
        check("reenable_release_quiet", 32'(log_d.size()), 32'd0);
        btn_level = 4'b0010;
        run(4);
        exp_q = {4'h1};
        check_seq("repress");
        btn_level = 4'b0000;
        run(4);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) btn_level[i] = ~btn_level[i];
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clear = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
